// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver, LSB first. Synchronizes the serial line, validates the
// start bit at its half-bit point, then samples each data bit and the stop
// bit one full bit period apart. Good frames update data with a valid pulse;
// a low stop bit produces a framing_error pulse and leaves data untouched.
module uart_byte_receiver #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       INITIALIZE,
  input  logic       UART_RX,
  output logic [7:0] data,
  output logic       valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic            s1_q, rx_s_q, rx_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bitidx_q, bitidx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  // State registers, synchronizer and edge-detect copy; INITIALIZE overrides all.
  always_ff @(posedge CLK) begin
    if (INITIALIZE) begin
      state_q   <= StIdle;
      s1_q      <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      bitidx_q  <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= UART_RX;
      rx_s_q    <= s1_q;
      rx_prev_q <= rx_s_q;
      cnt_q     <= cnt_d;
      bitidx_q  <= bitidx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // Frame sequencing: start validation, bit sampling and stop-bit check.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitidx_d = bitidx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Only a true high-to-low transition arms the receiver, so a held
        // break cannot retrigger until the line has gone high again.
        if (rx_prev_q && !rx_s_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d  = StData;
            bitidx_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          shift_d  = {rx_s_q, shift_q[7:1]};
          cnt_d    = '0;
          bitidx_d = bitidx_q + 3'd1;
          if (bitidx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign data          = data_q;
  assign valid         = valid_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Self-checking bench for uart_byte_receiver at 16 clocks per bit. Frames are
// driven as ideal bit periods; expected pulse timing and contents come from
// the frame timeline (start edge + fixed latency) and a last-good-byte model.
module tb_uart_byte_receiver;

  localparam int unsigned CPB = 16;
  localparam int unsigned Lat = 2 + CPB / 2 + 9 * CPB;  // e0 to pulse cycle

  logic       CLK = 1'b0;
  logic       INITIALIZE;
  logic       UART_RX;
  logic [7:0] data;
  logic       valid;
  logic       framing_error;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  int unsigned cyc = 0;
  logic [7:0]  last_good = 8'h00;

  // Observed pulses: kind 1 = valid, 2 = framing_error.
  int unsigned ev_cyc[$];
  int          ev_kind[$];
  logic [7:0]  ev_data[$];
  int          both_high = 0;

  uart_byte_receiver #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLK          (CLK),
    .INITIALIZE   (INITIALIZE),
    .UART_RX      (UART_RX),
    .data         (data),
    .valid        (valid),
    .framing_error(framing_error),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Record every output pulse, sampled mid-cycle.
  always @(negedge CLK) begin
    if (valid === 1'b1) begin
      ev_cyc.push_back(cyc);
      ev_kind.push_back(1);
      ev_data.push_back(data);
    end
    if (framing_error === 1'b1) begin
      ev_cyc.push_back(cyc);
      ev_kind.push_back(2);
      ev_data.push_back(data);
    end
    if (valid === 1'b1 && framing_error === 1'b1) both_high++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clear_events();
    ev_cyc.delete();
    ev_kind.delete();
    ev_data.delete();
  endtask

  // Drives one frame; e0 is the edge that first samples the start bit low.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            output int unsigned e0);
    UART_RX = 1'b0;
    e0 = cyc + 1;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      tick(CPB);
    end
    UART_RX = stop_bit;
    tick(CPB);
  endtask

  task automatic test_reset();
    int n_ev;
    UART_RX = 1'b1;
    INITIALIZE = 1'b1;
    tick(3);
    INITIALIZE = 1'b0;
    checks++;
    if (data !== 8'h00) begin
      failures++; $display("FAIL reset_data: got %0h expected 00", data);
    end
    checks++;
    if (valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b expected 0", valid);
    end
    checks++;
    if (framing_error !== 1'b0) begin
      failures++; $display("FAIL reset_ferr: got %b expected 0", framing_error);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    clear_events();
    tick(500);
    n_ev = ev_cyc.size();
    checks++;
    if (n_ev !== 0) begin
      failures++; $display("FAIL idle_pulses: got %0d pulses expected 0", n_ev);
    end
    last_good = 8'h00;
  endtask

  task automatic test_single_byte();
    int unsigned e0;
    int bad = 0;
    clear_events();
    send_frame(8'hA5, 1'b1, e0);
    UART_RX = 1'b1;
    tick(4);
    checks++;
    if (ev_cyc.size() !== 1) begin
      failures++; $display("FAIL a5_count: got %0d pulses expected 1", ev_cyc.size());
    end else begin
      checks++;
      if (ev_kind[0] !== 1) begin
        failures++; $display("FAIL a5_kind: got %0d expected 1", ev_kind[0]);
      end
      checks++;
      if (ev_cyc[0] !== e0 + Lat) begin
        failures++; $display("FAIL a5_time: got %0d expected %0d", ev_cyc[0] - e0, Lat);
      end
      checks++;
      if (ev_data[0] !== 8'hA5) begin
        failures++; $display("FAIL a5_data: got %0h expected a5", ev_data[0]);
      end
    end
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (data !== 8'hA5) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL a5_hold: data differed in %0d cycles expected 0", bad);
    end
    checks++;
    if (ev_cyc.size() !== 1) begin
      failures++; $display("FAIL a5_extra: got %0d pulses expected 1", ev_cyc.size());
    end
    last_good = 8'hA5;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bytes[3];
    int unsigned e0s[3];
    bytes[0] = 8'hFF;
    bytes[1] = 8'h00;
    bytes[2] = 8'h3C;
    clear_events();
    for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1, e0s[i]);
    UART_RX = 1'b1;
    tick(10);
    checks++;
    if (ev_cyc.size() !== 3) begin
      failures++; $display("FAIL b2b_count: got %0d pulses expected 3", ev_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ev_kind[i] !== 1 || ev_data[i] !== bytes[i] || ev_cyc[i] !== e0s[i] + Lat) begin
          failures++;
          $display("FAIL b2b_frame%0d: got kind %0d data %0h at +%0d expected 1 %0h +%0d",
                   i, ev_kind[i], ev_data[i], ev_cyc[i] - e0s[i], bytes[i], Lat);
        end
      end
      checks++;
      if (ev_cyc[2] - ev_cyc[1] !== 160 || ev_cyc[1] - ev_cyc[0] !== 160) begin
        failures++;
        $display("FAIL b2b_spacing: got %0d and %0d expected 160",
                 ev_cyc[1] - ev_cyc[0], ev_cyc[2] - ev_cyc[1]);
      end
    end
    last_good = 8'h3C;
  endtask

  task automatic test_glitch_framing();
    int unsigned g0, e0;
    clear_events();
    UART_RX = 1'b0;
    g0 = cyc + 1;
    tick(4);
    UART_RX = 1'b1;
    tick(6);  // just after edge g0+9: still validating the start
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL glitch_busy_hi: got %b expected 1 at +%0d", busy, cyc - g0);
    end
    tick(1);  // just after the start check at g0+10
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL glitch_busy_lo: got %b expected 0 at +%0d", busy, cyc - g0);
    end
    tick(20);
    checks++;
    if (ev_cyc.size() !== 0) begin
      failures++; $display("FAIL glitch_pulse: got %0d pulses expected 0", ev_cyc.size());
    end
    clear_events();
    send_frame(8'h55, 1'b0, e0);
    UART_RX = 1'b1;
    tick(5);
    checks++;
    if (ev_cyc.size() !== 1 || ev_kind[0] !== 2 || ev_cyc[0] !== e0 + Lat) begin
      failures++;
      $display("FAIL ferr_pulse: got %0d pulses first kind %0d expected 1 pulse kind 2 at +%0d",
               ev_cyc.size(), (ev_kind.size() > 0) ? ev_kind[0] : 0, Lat);
    end
    checks++;
    if (data !== last_good) begin
      failures++; $display("FAIL ferr_data_kept: got %0h expected %0h", data, last_good);
    end
    clear_events();
    send_frame(8'h12, 1'b1, e0);
    UART_RX = 1'b1;
    tick(5);
    checks++;
    if (ev_cyc.size() !== 1 || ev_kind[0] !== 1 || ev_data[0] !== 8'h12) begin
      failures++;
      $display("FAIL after_ferr: got %0d pulses data %0h expected 1 valid with 12",
               ev_cyc.size(), data);
    end
    last_good = 8'h12;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0]  b = 8'hC3;
    int unsigned e0;
    clear_events();
    UART_RX = 1'b0;
    tick(CPB);
    for (int i = 0; i < 6; i++) begin
      UART_RX = b[i];
      tick(CPB);
    end
    // Reset lands inside high bit 6, so the freshly reset synchronizer does
    // not see a low level it would mistake for a new start edge.
    UART_RX = b[6];
    tick(8);
    INITIALIZE = 1'b1;
    tick(1);
    INITIALIZE = 1'b0;
    checks++;
    if (busy !== 1'b0 || data !== 8'h00) begin
      failures++; $display("FAIL midreset_state: got busy %b data %0h expected 0 00", busy, data);
    end
    tick(7);
    UART_RX = b[7];
    tick(CPB);
    UART_RX = 1'b1;
    tick(CPB + 4);
    checks++;
    if (ev_cyc.size() !== 0) begin
      failures++; $display("FAIL midreset_abort: got %0d pulses expected 0", ev_cyc.size());
    end
    send_frame(8'h7E, 1'b1, e0);
    UART_RX = 1'b1;
    tick(5);
    checks++;
    if (ev_cyc.size() !== 1 || ev_kind[0] !== 1 || ev_data[0] !== 8'h7E ||
        ev_cyc[0] !== e0 + Lat) begin
      failures++;
      $display("FAIL midreset_next: got %0d pulses data %0h expected 1 valid with 7e",
               ev_cyc.size(), data);
    end
    last_good = 8'h7E;
  endtask

  task automatic test_break();
    int unsigned b0, e0;
    clear_events();
    UART_RX = 1'b0;
    b0 = cyc + 1;
    tick(399);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL break_rearm: got busy %b expected 0 while held low", busy);
    end
    tick(1);
    UART_RX = 1'b1;
    tick(5);
    checks++;
    if (ev_cyc.size() !== 1 || ev_kind[0] !== 2 || ev_cyc[0] !== b0 + Lat) begin
      failures++;
      $display("FAIL break_ferr: got %0d pulses expected exactly one framing_error",
               ev_cyc.size());
    end
    checks++;
    if (data !== last_good) begin
      failures++; $display("FAIL break_data: got %0h expected %0h", data, last_good);
    end
    clear_events();
    send_frame(8'h81, 1'b1, e0);
    UART_RX = 1'b1;
    tick(5);
    checks++;
    if (ev_cyc.size() !== 1 || ev_kind[0] !== 1 || ev_data[0] !== 8'h81) begin
      failures++;
      $display("FAIL break_next: got %0d pulses data %0h expected 1 valid with 81",
               ev_cyc.size(), data);
    end
    last_good = 8'h81;
  endtask

  task automatic test_random();
    int unsigned exp_cyc[$];
    int          exp_kind[$];
    logic [7:0]  exp_data[$];
    int unsigned e0;
    logic [7:0]  b;
    logic        stop_bit;
    int          n;
    clear_events();
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      stop_bit = ($urandom_range(0, 3) != 0);
      send_frame(b, stop_bit, e0);
      exp_cyc.push_back(e0 + Lat);
      if (stop_bit) begin
        last_good = b;
        exp_kind.push_back(1);
      end else begin
        exp_kind.push_back(2);
      end
      exp_data.push_back(last_good);
      UART_RX = 1'b1;
      // A low stop bit needs the line high again before the next start edge.
      tick(stop_bit ? $urandom_range(0, 12) : $urandom_range(3, 12));
    end
    tick(10);
    checks++;
    if (ev_cyc.size() !== exp_cyc.size()) begin
      failures++;
      $display("FAIL rand_count: got %0d pulses expected %0d", ev_cyc.size(), exp_cyc.size());
    end
    n = (ev_cyc.size() < exp_cyc.size()) ? ev_cyc.size() : exp_cyc.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (ev_cyc[i] !== exp_cyc[i] || ev_kind[i] !== exp_kind[i] ||
          ev_data[i] !== exp_data[i]) begin
        failures++;
        $display("FAIL rand_frame%0d: got cyc %0d kind %0d data %0h expected %0d %0d %0h",
                 i, ev_cyc[i], ev_kind[i], ev_data[i], exp_cyc[i], exp_kind[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_high !== 0) begin
      failures++;
      $display("FAIL pulse_exclusive: valid and framing_error together %0d times expected 0",
               both_high);
    end
  endtask

  initial begin
    INITIALIZE = 1'b1;
    UART_RX = 1'b1;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch_framing();
    test_reset_mid_frame();
    test_break();
    test_random();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
